// File: rtl/inst_buffer_pkg.sv
// Shared pipeline types for the decode/issue boundary: instruction record,
// issue mask and the default instruction-buffer depth.
package inst_buffer_pkg;

    localparam int INST_BUF_DEPTH = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] raw;
    } inst_t;

    // Issue-stage pop mask; only 2'b00, 2'b01 and 2'b11 are legal.
    typedef logic [1:0] issue_mask_t;

    function automatic logic [1:0] mask_count(input logic [1:0] m);
        return {1'b0, m[0]} + {1'b0, m[1]};
    endfunction

endpackage

// File: rtl/inst_buffer_ram.sv
// Instruction storage: two write ports at consecutive slots, two combinational
// read ports at consecutive slots. Storage is never reset.
module inst_buffer_ram
    import inst_buffer_pkg::*;
#(
    parameter int  DEPTH = INST_BUF_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic [1:0]            we,
    input  logic [1:0][PTR_W-1:0] waddr,
    input  inst_t [1:0]           wdata,
    input  logic [1:0][PTR_W-1:0] raddr,
    output inst_t [1:0]           rdata
);

    inst_t mem [DEPTH];

    // Both ports share one process; the top guarantees distinct addresses.
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (we[p]) begin
                mem[waddr[p]] <= wdata[p];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            assign rdata[gi] = mem[raddr[gi]];
        end
    endgenerate

endmodule

// File: rtl/inst_buffer.sv
// Dual-issue in-order instruction queue between decode and issue: pointers,
// occupancy, ready/valid handshakes and protocol assertions.
module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int  DEPTH = INST_BUF_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  inst_t [1:0]   d_inst_i,
    input  logic [1:0]    d_valid_i,
    output logic          d_ready_o,
    output inst_t [1:0]   inst_o,
    output logic [1:0]    valid_o,
    input  issue_mask_t   is_i,
    output logic [PTR_W:0] count_o
);

    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 2);

    logic [PTR_W-1:0] head_reg, head_next;
    logic [PTR_W-1:0] tail_reg, tail_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             push_en;
    logic [1:0]       we;
    logic [1:0]       npush;
    logic [1:0]       npop;
    logic [1:0][PTR_W-1:0] waddr;
    logic [1:0][PTR_W-1:0] raddr;

    // Ready looks only at the registered count so a same-cycle pop never frees space.
    assign d_ready_o = (count_reg <= READY_MAX);
    assign valid_o   = {count_reg >= CNT_W'(2), count_reg >= CNT_W'(1)};
    assign count_o   = count_reg;

    always_comb begin
        push_en    = d_ready_o & ~flush_i;
        we         = d_valid_i & {2{push_en}};
        npush      = mask_count(we);
        npop       = flush_i ? 2'd0 : mask_count(is_i);
        waddr[0]   = tail_reg;
        waddr[1]   = tail_reg + PTR_W'(1);
        raddr[0]   = head_reg;
        raddr[1]   = head_reg + PTR_W'(1);
        head_next  = head_reg + PTR_W'(npop);
        tail_next  = tail_reg + PTR_W'(npush);
        count_next = count_reg + CNT_W'(npush) - CNT_W'(npop);
        if (flush_i) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    inst_buffer_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (d_inst_i),
        .raddr (raddr),
        .rdata (inst_o)
    );

`ifndef SYNTHESIS
    a_dvalid_legal: assert property (@(posedge clk) disable iff (rst) d_valid_i != 2'b10);
    a_issue_legal:  assert property (@(posedge clk) disable iff (rst) is_i != 2'b10);
    a_issue_subset: assert property (@(posedge clk) disable iff (rst) (is_i & ~valid_o) == 2'b00);
    a_count_max:    assert property (@(posedge clk) disable iff (rst) count_reg <= CNT_W'(DEPTH));
    // Low bits of count equal the pointer distance; a full buffer wraps to zero distance.
    a_count_ptrs:   assert property (@(posedge clk) disable iff (rst)
                                     count_reg[PTR_W-1:0] == PTR_W'(tail_reg - head_reg));
`endif

endmodule

// File: tb/tb_inst_buffer.sv
// Randomized scoreboard bench for inst_buffer against a queue-based reference.
module tb_inst_buffer;
    import inst_buffer_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_i = 1'b0;
    inst_t [1:0] d_inst_i = '0;
    logic [1:0]  d_valid_i = 2'b00;
    logic        d_ready_o;
    inst_t [1:0] inst_o;
    logic [1:0]  valid_o;
    issue_mask_t is_i = 2'b00;
    logic [3:0]  count_o;

    inst_buffer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush_i   (flush_i),
        .d_inst_i  (d_inst_i),
        .d_valid_i (d_valid_i),
        .d_ready_o (d_ready_o),
        .inst_o    (inst_o),
        .valid_o   (valid_o),
        .is_i      (is_i),
        .count_o   (count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   count;
        logic ready;
        logic [1:0] valid;
        inst_t i0;
        inst_t i1;
    } snap_t;

    inst_t model_q[$];
    snap_t exp_q[$];
    snap_t async_q[$];
    int    tests = 0;
    int    fails = 0;
    event  async_ev;

    function automatic snap_t snapshot();
        snap_t s;
        s.count = model_q.size();
        s.ready = (s.count <= DEPTH - 2);
        s.valid = {s.count >= 2, s.count >= 1};
        s.i0    = (s.count >= 1) ? model_q[0] : '0;
        s.i1    = (s.count >= 2) ? model_q[1] : '0;
        return s;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic compare_snap(input snap_t s, input string where);
        $display("[TB] %s t=%0t count=%0d valid=%b ready=%b", where, $time, count_o, valid_o, d_ready_o);
        check({where, " count"}, 64'(count_o), 64'(s.count));
        check({where, " ready"}, 64'(d_ready_o), 64'(s.ready));
        check({where, " valid"}, 64'(valid_o), 64'(s.valid));
        if (s.valid[0]) check({where, " inst0"}, 64'(inst_o[0]), 64'(s.i0));
        if (s.valid[1]) check({where, " inst1"}, 64'(inst_o[1]), 64'(s.i1));
    endtask

    // Monitors: one samples after every rising edge, one checks asynchronous reset.
    initial begin
        snap_t s;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                s = exp_q.pop_front();
                compare_snap(s, "sync");
            end
        end
    end

    initial begin
        snap_t s;
        forever begin
            @(async_ev);
            if (async_q.size() > 0) begin
                s = async_q.pop_front();
                compare_snap(s, "async");
            end
        end
    end

    function automatic inst_t rand_inst();
        inst_t x;
        x.pc  = $urandom;
        x.raw = $urandom;
        return x;
    endfunction

    task automatic step(input logic [1:0] dv, input logic [1:0] is, input logic fl, input logic r);
        inst_t a;
        inst_t b;
        bit    rdy;
        int    npop;
        @(negedge clk);
        a = rand_inst();
        b = rand_inst();
        rst         = r;
        flush_i     = fl;
        d_valid_i   = dv;
        d_inst_i[0] = a;
        d_inst_i[1] = b;
        is_i        = is;
        if (r || fl) begin
            model_q.delete();
        end else begin
            rdy  = (model_q.size() <= DEPTH - 2);
            npop = int'(is[0]) + int'(is[1]);
            repeat (npop) void'(model_q.pop_front());
            if (rdy) begin
                if (dv[0]) model_q.push_back(a);
                if (dv[1]) model_q.push_back(b);
            end
        end
        exp_q.push_back(snapshot());
        if (r) begin
            #1;
            async_q.push_back(snapshot());
            ->async_ev;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] dv;
        logic [1:0] is;
        int         k;
        int         sz;
        step(2'b00, 2'b00, 1'b0, 1'b1);                 // reset state
        step(2'b11, 2'b00, 1'b0, 1'b0);                 // push A,B
        step(2'b00, 2'b11, 1'b0, 1'b0);
        repeat (4) step(2'b11, 2'b00, 1'b0, 1'b0);      // fill to DEPTH
        repeat (2) step(2'b11, 2'b00, 1'b0, 1'b0);      // ignored while full
        repeat (4) step(2'b00, 2'b11, 1'b0, 1'b0);
        step(2'b11, 2'b00, 1'b0, 1'b0);
        repeat (20) step(2'b11, 2'b11, 1'b0, 1'b0);     // wrap at steady count 2
        step(2'b01, 2'b00, 1'b0, 1'b0);
        step(2'b01, 2'b11, 1'b0, 1'b0);                 // count 3 -> 2
        step(2'b11, 2'b11, 1'b1, 1'b0);                 // flush wins
        step(2'b11, 2'b00, 1'b0, 1'b0);
        step(2'b11, 2'b00, 1'b0, 1'b0);
        step(2'b01, 2'b00, 1'b0, 1'b0);                 // count 5
        step(2'b11, 2'b01, 1'b0, 1'b1);                 // async reset mid-stream
        step(2'b11, 2'b00, 1'b0, 1'b0);
        step(2'b11, 2'b00, 1'b0, 1'b0);
        step(2'b00, 2'b01, 1'b0, 1'b0);
        for (int n = 0; n < 300; n++) begin
            sz = model_q.size();
            k  = $urandom_range(0, (sz < 2) ? sz : 2);
            is = (k == 0) ? 2'b00 : (k == 1) ? 2'b01 : 2'b11;
            k  = $urandom_range(0, 2);
            dv = (k == 0) ? 2'b00 : (k == 1) ? 2'b01 : 2'b11;
            step(dv, is, ($urandom_range(0, 31) == 0), 1'b0);
        end
        step(2'b00, 2'b00, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        check("drain", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
